store_drain: RTL



---
 rtl/store_drain.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/store_drain.sv
// store_drain: unload side of the load/store volume interface.
//
// On each loader "full" indication seen while idle, latches a volume of N units and drains it
// to a downstream sink in chunks of at most CHUNK units over a valid/ready handshake. When the
// volume reaches zero, empty pulses for one cycle so the loader can resume filling.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous, active-high reset
//   full         loader-full level; sampled only in the idle state
//   out_valid    chunk transfer offered
//   out_ready    downstream accepts the offered chunk
//   out_amt      units in the offered chunk (CBITS)
//   vol          remaining volume (CBITS)
//   draining     high while a drain is in progress
//   empty        one-cycle pulse when a drain completes
//   overrun_cnt  (only with STORE_DRAIN_OVERRUN_CNT_EN) saturating count of cycles with full
//                high while not idle
//
// Optional feature macro: STORE_DRAIN_OVERRUN_CNT_EN.
//
// Parameter constraints: 1 <= N < 2**CBITS, 1 <= CHUNK <= N.

module store_drain #(
  parameter int unsigned N     = 25000,
  parameter int unsigned CBITS = 15,
  parameter int unsigned CHUNK = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CBITS-1:0] out_amt,
  output logic [CBITS-1:0] vol,
  output logic             draining,
  output logic             empty
`ifdef STORE_DRAIN_OVERRUN_CNT_EN
  ,
  output logic [7:0]       overrun_cnt
`endif
);

  localparam logic [CBITS-1:0] NVol   = CBITS'(N);
  localparam logic [CBITS-1:0] ChunkW = CBITS'(CHUNK);
  // First chunk of every drain: min(CHUNK, N) in CBITS unsigned.
  localparam logic [CBITS-1:0] FirstAmt = (ChunkW < NVol) ? ChunkW : NVol;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CBITS-1:0] vol_q, vol_d;
  logic [CBITS-1:0] amt_q, amt_d;
  logic             valid_q, valid_d;
  logic             draining_q, draining_d;
  logic             empty_q, empty_d;

  logic             accept;
  logic [CBITS-1:0] remain;

  assign accept = valid_q && out_ready;
  // amt_q <= vol_q holds throughout a drain, so this never wraps.
  assign remain = vol_q - amt_q;

  always_comb begin
    state_d    = state_q;
    vol_d      = vol_q;
    amt_d      = amt_q;
    valid_d    = valid_q;
    draining_d = draining_q;
    empty_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (full) begin
          vol_d      = NVol;
          amt_d      = FirstAmt;
          valid_d    = 1'b1;
          draining_d = 1'b1;
          state_d    = StDrain;
        end
      end

      StDrain: begin
        if (accept) begin
          if (remain != '0) begin
            vol_d = remain;
            amt_d = (remain < ChunkW) ? remain : ChunkW;
          end else begin
            vol_d      = '0;
            amt_d      = '0;
            valid_d    = 1'b0;
            draining_d = 1'b0;
            empty_d    = 1'b1;
            state_d    = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d    = StIdle;
        vol_d      = '0;
        amt_d      = '0;
        valid_d    = 1'b0;
        draining_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      vol_q      <= '0;
      amt_q      <= '0;
      valid_q    <= 1'b0;
      draining_q <= 1'b0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vol_q      <= vol_d;
      amt_q      <= amt_d;
      valid_q    <= valid_d;
      draining_q <= draining_d;
      empty_q    <= empty_d;
    end
  end

  assign out_valid = valid_q;
  assign out_amt   = amt_q;
  assign vol       = vol_q;
  assign draining  = draining_q;
  assign empty     = empty_q;

`ifdef STORE_DRAIN_OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;

  // Counts full indications the drain cannot act on; purely observational.
  always_comb begin
    overrun_d = overrun_q;
    if (full && (state_q != StIdle) && (overrun_q != 8'hff)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 8'd0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_cnt = overrun_q;
`endif

endmodule
